// File: rtl/vect_scaler_pkg.sv
// rtl/vect_scaler_pkg.sv - shared Q-format constants and lane geometry for the vector datapath
`ifndef N_MAX
`define N_MAX 4
`endif

package vect_scaler_pkg;

  // Q(WIDTH-FRAC).FRAC signed fixed-point format shared with the vector adder
  localparam int FIX_WIDTH = 43;
  localparam int FIX_FRAC  = 32;

  localparam logic signed [FIX_WIDTH-1:0] FIX_MAX = {1'b0, {(FIX_WIDTH-1){1'b1}}};
  localparam logic signed [FIX_WIDTH-1:0] FIX_MIN = {1'b1, {(FIX_WIDTH-1){1'b0}}};
  localparam logic signed [FIX_WIDTH-1:0] FIX_ONE =
    {{(FIX_WIDTH-FIX_FRAC-1){1'b0}}, 1'b1, {FIX_FRAC{1'b0}}};

  // Lane count and width of the active-lane count
  localparam int N_LANES = `N_MAX;
  localparam int NW      = $clog2(`N_MAX + 1);

endpackage

// File: rtl/fix_round_sat.sv
// rtl/fix_round_sat.sv - round-half-up and saturate a double-width product back to Q format
module fix_round_sat
  import vect_scaler_pkg::*;
#(
  parameter int WIDTH = FIX_WIDTH,
  parameter int FRAC  = FIX_FRAC
) (
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   res,
  output logic               sat
);

  // One guard bit so adding the rounding half can never wrap the product
  localparam int SW = 2*WIDTH + 1;

  localparam logic [SW-1:0] HALF = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [SW-1:0] R_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] R_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  assign sum     = {prod[2*WIDTH-1], prod} + HALF;
  assign shifted = sum >>> FRAC;

  // Clamp the rounded value to the representable range and flag any clamp
  always_comb begin
    res = shifted[WIDTH-1:0];
    sat = 1'b0;
    if (shifted > R_MAX) begin
      res = R_MAX[WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < R_MIN) begin
      res = R_MIN[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/vect_scaler.sv
// rtl/vect_scaler.sv - two-stage element-wise fixed-point vector-by-scalar multiplier
module vect_scaler
  import vect_scaler_pkg::*;
#(
  parameter int WIDTH = FIX_WIDTH,
  parameter int FRAC  = FIX_FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_LANES*WIDTH-1:0] vect_in,
  input  logic [WIDTH-1:0]         scalar,
  input  logic [NW-1:0]            n_active,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LANES*WIDTH-1:0] vect_out,
  output logic                     out_sat
);

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  logic [2*WIDTH-1:0]                  scalar_ext;
  logic [N_LANES-1:0][2*WIDTH-1:0]     prod_d;
  logic [N_LANES-1:0][2*WIDTH-1:0]     prod_q;
  logic [N_LANES-1:0][WIDTH-1:0]       lane_res;
  logic [N_LANES-1:0]                  lane_sat;

  // No skid buffer: a stage moves whenever the stage after it can take its contents
  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Sign-extended operands give the exact signed product in the low 2*WIDTH bits
  assign scalar_ext = {{WIDTH{scalar[WIDTH-1]}}, scalar};

  // Per-lane full products; inactive lanes become zero before they are registered
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (NW'(i) < n_active) begin
        prod_d[i] = {{WIDTH{vect_in[i*WIDTH+WIDTH-1]}}, vect_in[i*WIDTH +: WIDTH]} * scalar_ext;
      end
    end
  end

  // Stage 1: capture products on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      prod_q   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        prod_q <= prod_d;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_LANES; g++) begin : g_lane
      fix_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
      ) u_round_sat (
        .prod (prod_q[g]),
        .res  (lane_res[g]),
        .sat  (lane_sat[g])
      );
    end
  endgenerate

  // Stage 2: register rounded/saturated lanes; output holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      vect_out <= '0;
      out_sat  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        vect_out <= lane_res;
        out_sat  <= |lane_sat;
      end
    end
  end

endmodule

// File: tb/tb_vect_scaler.sv
// tb/tb_vect_scaler.sv - scoreboard bench for vect_scaler with random and directed vectors
`timescale 1ns/1ps
`ifndef N_MAX
`define N_MAX 4
`endif

module tb_vect_scaler;
  import vect_scaler_pkg::*;

  localparam int W = FIX_WIDTH;
  localparam int F = FIX_FRAC;
  localparam int N = `N_MAX;

  typedef logic [N*W-1:0] vec_t;
  typedef struct packed {
    vec_t v;
    logic s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vec_t          vect_in;
  logic [W-1:0]  scalar;
  logic [NW-1:0] n_active;
  logic          out_valid;
  logic          out_ready;
  vec_t          vect_out;
  logic          out_sat;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   accepted = 0;
  int   rdy_mode = 0;

  vect_scaler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vect_in   (vect_in),
    .scalar    (scalar),
    .n_active  (n_active),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vect_out  (vect_out),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: exact product, round half up, clamp to the format range
  function automatic exp_t model(input vec_t v, input logic [W-1:0] s, input int n);
    logic signed [127:0] a, b, p, r, maxv, minv;
    exp_t e;
    e.v  = '0;
    e.s  = 1'b0;
    maxv = (128'sd1 <<< (W-1)) - 1;
    minv = -(128'sd1 <<< (W-1));
    b    = $signed(s);
    for (int i = 0; i < N; i++) begin
      if (i < n) begin
        a = $signed(v[i*W +: W]);
        p = a * b;
        r = (p + (128'sd1 <<< (F-1))) >>> F;
        if (r > maxv) begin
          r = maxv;
          e.s = 1'b1;
        end else if (r < minv) begin
          r = minv;
          e.s = 1'b1;
        end
        e.v[i*W +: W] = r[W-1:0];
      end
    end
    return e;
  endfunction

  // Out_ready policy: 0 = always ready, 1 = random, 2 = left to the test
  always @(negedge clk) begin
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Present one vector and hold it until accepted; expected response goes to the scoreboard
  task automatic send(input vec_t v, input logic [W-1:0] s, input logic [NW-1:0] n, input exp_t e);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    vect_in  = v;
    scalar   = s;
    n_active = n;
    #4;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #4;
      t++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", 256'(in_ready), 256'(1));
    end else begin
      sb.push_back(e);
      accepted++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(sb.size() == 0, "drain", 256'(sb.size()), 256'(0));
  endtask

  function automatic vec_t lanes(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                 input logic [W-1:0] lr);
    vec_t v;
    for (int i = 0; i < N; i++) v[i*W +: W] = lr;
    v[0 +: W] = l0;
    v[W +: W] = l1;
    return v;
  endfunction

  // Monitor: pop and compare on every output transfer, and check hold while stalled
  initial begin
    bit   prev_stall = 1'b0;
    vec_t prev_vec   = '0;
    logic prev_sat   = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check(out_valid && vect_out == prev_vec && out_sat == prev_sat, "stall_hold",
                256'({out_valid, out_sat, vect_out}), 256'({1'b1, prev_sat, prev_vec}));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_output", 256'(vect_out), 256'(0));
          end else begin
            e = sb.pop_front();
            check(vect_out == e.v, "vect_out", 256'(vect_out), 256'(e.v));
            check(out_sat == e.s, "out_sat", 256'(out_sat), 256'(e.s));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_vec   = vect_out;
        prev_sat   = out_sat;
      end
    end
  end

  initial begin
    exp_t e;
    vec_t v;
    logic signed [W-1:0] x;
    logic [W-1:0] s;
    logic [NW-1:0] n;

    rst = 1'b1; in_valid = 1'b0; vect_in = '0; scalar = '0; n_active = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check(out_valid == 1'b0, "reset_out_valid", 256'(out_valid), 256'(0));
    check(out_sat == 1'b0, "reset_out_sat", 256'(out_sat), 256'(0));
    check(vect_out == '0, "reset_vect_out", 256'(vect_out), 256'(0));
    check(in_ready == 1'b1, "reset_in_ready", 256'(in_ready), 256'(1));

    // Basic 1.5 * 2.0 with latency check
    e.v = lanes(43'h3_0000_0000, '0, '0); e.s = 1'b0;
    send(lanes(43'h1_8000_0000, '0, '0), 43'h2_0000_0000, NW'(4), e);
    @(negedge clk); in_valid = 1'b0; #4;
    check(out_valid == 1'b0, "latency_cycle1", 256'(out_valid), 256'(0));
    @(negedge clk); #4;
    check(out_valid == 1'b1, "latency_cycle2", 256'(out_valid), 256'(1));
    wait_empty();

    // Saturation both ways
    e.v = lanes(43'h3FF_FFFF_FFFF, 43'h400_0000_0000, '0); e.s = 1'b1;
    send(lanes(43'h200_0000_0000, 43'h600_0000_0000, '0), 43'h4_0000_0000, NW'(4), e);
    // Rounding of +/- one LSB times 0.5
    e.v = lanes(43'h1, 43'h0, '0); e.s = 1'b0;
    send(lanes(43'h1, 43'h7FF_FFFF_FFFF, '0), 43'h8000_0000, NW'(4), e);
    // Masking with n_active = 2 and 0
    e.v = lanes(43'h3_0000_0000, 43'h3_0000_0000, '0); e.s = 1'b0;
    send(lanes(43'h1_0000_0000, 43'h1_0000_0000, 43'h1_0000_0000), 43'h3_0000_0000, NW'(2), e);
    e.v = '0; e.s = 1'b0;
    send(lanes(43'h200_0000_0000, 43'h1_0000_0000, 43'h200_0000_0000), 43'h4_0000_0000, NW'(0), e);
    idle();
    wait_empty();

    // Backpressure: five vectors against a four-cycle stall
    rdy_mode = 2;
    @(negedge clk); out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          v = lanes(W'(k + 1) << F, W'(k) << F, W'(7) << (F - 1));
          send(v, 43'h1_4000_0000, NW'(N), model(v, 43'h1_4000_0000, N));
        end
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        #4;
        check(in_ready == 1'b0, "bp_in_ready", 256'(in_ready), 256'(0));
        check(accepted == 2, "bp_accepted", 256'(accepted), 256'(2));
        @(negedge clk);
        out_ready = 1'b1;
        rdy_mode = 0;
      end
    join
    wait_empty();

    // Reset with two vectors in flight: nothing of them may emerge
    rdy_mode = 2;
    @(negedge clk); out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v = lanes(W'(k + 9) << F, '0, '0);
      send(v, 43'h1_0000_0000, NW'(1), model(v, 43'h1_0000_0000, 1));
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    rdy_mode = 0;
    #4;
    check(out_valid == 1'b0, "rst_mid_out_valid", 256'(out_valid), 256'(0));
    check(in_ready == 1'b1, "rst_mid_in_ready", 256'(in_ready), 256'(1));
    repeat (4) @(negedge clk);

    // Random traffic with random backpressure and gaps
    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        x = W'({$urandom, $urandom});
        x = x >>> $urandom_range(0, W - 1);
        v[i*W +: W] = x;
      end
      x = W'({$urandom, $urandom});
      s = W'(x >>> $urandom_range(20, W - 1));
      n = NW'($urandom_range(0, (1 << NW) - 1));
      send(v, s, n, model(v, s, int'(n)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rdy_mode = 0;
    wait_empty();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
